// File: rtl/trace_pkg.sv
// Shared trace record layout, flag bit positions and monitor states
// for the retire trace buffer.
package trace_pkg;

  localparam int FLAG_REG   = 0;
  localparam int FLAG_LOAD  = 1;
  localparam int FLAG_STORE = 2;
  localparam int FLAG_HALT  = 3;

  localparam int TR_DATA_W = 16;
  localparam int TR_ADDR_W = 16;
  localparam int TR_REG_W  = 4;
  localparam int TR_CNT_W  = 32;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE,
    TIMEOUT
  } state_t;

  typedef struct packed {
    logic [3:0]           flags;
    logic [TR_ADDR_W-1:0] pc;
    logic [TR_REG_W-1:0]  rd;
    logic [TR_DATA_W-1:0] regData;
    logic [TR_ADDR_W-1:0] memAddr;
    logic [TR_DATA_W-1:0] memData;
`ifdef CYCLE_STAMP_EN
    logic [TR_CNT_W-1:0]  cycle;
`endif
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is taken
// only when a pop frees a slot on the same edge.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] wrPtr;
  logic [PW:0] rdPtr;
  logic doPush;
  logic doPop;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[PW] != rdPtr[PW]) &&
                 (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign count = wrPtr - rdPtr;
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdata  = mem[rdPtr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// WB-stage retire monitor: classifies, queues and drains trace records.
// Define CYCLE_STAMP_EN to add out_cycle, the capture-time cycle stamp.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int REG_W     = 4,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 32,
  parameter int CYC_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic              wb_reg_wr,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_reg_data,
  input  logic              wb_mem_rd,
  input  logic              wb_mem_wr,
  input  logic [ADDR_W-1:0] wb_mem_addr,
  input  logic [DATA_W-1:0] wb_mem_wdata,
  input  logic [DATA_W-1:0] wb_mem_rdata,
  input  logic              wb_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_flags,
  output logic [ADDR_W-1:0] out_pc,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_reg_data,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              done,
  output logic              timeout
`ifdef CYCLE_STAMP_EN
  ,
  output logic [CNT_W-1:0]  out_cycle
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int RECW = $bits(trace_rec_t);
  localparam logic [PW:0] ONE_ENTRY = {{PW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(CYC_LIMIT);

  state_t state;
  trace_rec_t rec;
  trace_rec_t head;
  trace_rec_t outRec;
  logic [RECW-1:0] fifoData;
  logic [PW:0] fifoCount;
  logic fifoFull;
  logic fifoEmpty;
  logic running;
  logic isLoad;
  logic isStore;
  logic capture;
  logic pop;
  logic drop;
  logic instInc;
  logic tick;
  logic hitLimit;
  logic drainEmpty;
  logic [CNT_W-1:0] cycNext;

  assign running = (state == RUN);
  assign isLoad  = wb_mem_rd & ~wb_mem_wr;
  assign isStore = wb_mem_wr & ~wb_mem_rd;

  always_comb begin
    rec = '0;
    rec.flags[FLAG_REG]   = wb_reg_wr;
    rec.flags[FLAG_LOAD]  = isLoad;
    rec.flags[FLAG_STORE] = isStore;
    rec.flags[FLAG_HALT]  = wb_halt;
    rec.pc = TR_ADDR_W'(wb_pc);
    if (wb_reg_wr) begin
      rec.rd      = TR_REG_W'(wb_rd);
      rec.regData = TR_DATA_W'(wb_reg_data);
    end
    if (isLoad || isStore) rec.memAddr = TR_ADDR_W'(wb_mem_addr);
    unique case (1'b1)
      isLoad:  rec.memData = TR_DATA_W'(wb_mem_rdata);
      isStore: rec.memData = TR_DATA_W'(wb_mem_wdata);
      default: ;
    endcase
`ifdef CYCLE_STAMP_EN
    rec.cycle = TR_CNT_W'(cycle_count);
`endif
  end

  assign capture = running && (rec.flags != 4'b0000);
  assign pop     = out_valid && out_ready;
  assign drop    = capture && fifoFull && !pop;
  assign instInc = running && (wb_halt || wb_reg_wr || isStore);

  trace_fifo #(
    .WIDTH(RECW),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(capture),
    .wdata(rec),
    .pop(pop),
    .rdata(fifoData),
    .full(fifoFull),
    .empty(fifoEmpty),
    .count(fifoCount)
  );

  assign head      = trace_rec_t'(fifoData);
  assign out_valid = !fifoEmpty;
  assign outRec    = out_valid ? head : '0;

  assign out_flags    = outRec.flags;
  assign out_pc       = ADDR_W'(outRec.pc);
  assign out_rd       = REG_W'(outRec.rd);
  assign out_reg_data = DATA_W'(outRec.regData);
  assign out_mem_addr = ADDR_W'(outRec.memAddr);
  assign out_mem_data = DATA_W'(outRec.memData);
`ifdef CYCLE_STAMP_EN
  assign out_cycle    = CNT_W'(outRec.cycle);
`endif

  // Nothing is pushed while draining, so the last pop empties the FIFO.
  assign drainEmpty = fifoEmpty || (pop && fifoCount == ONE_ENTRY);
  assign tick       = (state == RUN) || (state == DRAIN);
  assign cycNext    = (cycle_count == '1) ? cycle_count
                                          : cycle_count + CNT_ONE;
  assign hitLimit   = tick && (cycNext > LIMIT_C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (tick) cycle_count <= cycNext;
      if (hitLimit) begin
        state   <= TIMEOUT;
        timeout <= 1'b1;
      end else begin
        unique case (state)
          RUN: begin
            if (capture && rec.flags[FLAG_HALT]) state <= DRAIN;
          end
          DRAIN: begin
            if (drainEmpty) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (instInc && inst_count != '1)
        inst_count <= inst_count + CNT_ONE;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_retire_trace_buffer;

  localparam int DEPTH = 16;
  localparam int LIMIT = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wb_pc = '0;
  logic        wb_reg_wr = 1'b0;
  logic [3:0]  wb_rd = '0;
  logic [15:0] wb_reg_data = '0;
  logic        wb_mem_rd = 1'b0;
  logic        wb_mem_wr = 1'b0;
  logic [15:0] wb_mem_addr = '0;
  logic [15:0] wb_mem_wdata = '0;
  logic [15:0] wb_mem_rdata = '0;
  logic        wb_halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_flags;
  logic [15:0] out_pc;
  logic [3:0]  out_rd;
  logic [15:0] out_reg_data;
  logic [15:0] out_mem_addr;
  logic [15:0] out_mem_data;
  logic [31:0] inst_count;
  logic [31:0] cycle_count;
  logic [31:0] drop_count;
  logic        overflow;
  logic        done;
  logic        timeout;
`ifdef CYCLE_STAMP_EN
  logic [31:0] out_cycle;
`endif

  always #5 clk = ~clk;

  retire_trace_buffer #(
    .DATA_W(16), .ADDR_W(16), .REG_W(4),
    .DEPTH(DEPTH), .CNT_W(32), .CYC_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_pc(wb_pc), .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd),
    .wb_reg_data(wb_reg_data), .wb_mem_rd(wb_mem_rd),
    .wb_mem_wr(wb_mem_wr), .wb_mem_addr(wb_mem_addr),
    .wb_mem_wdata(wb_mem_wdata), .wb_mem_rdata(wb_mem_rdata),
    .wb_halt(wb_halt), .out_valid(out_valid), .out_ready(out_ready),
    .out_flags(out_flags), .out_pc(out_pc), .out_rd(out_rd),
    .out_reg_data(out_reg_data), .out_mem_addr(out_mem_addr),
    .out_mem_data(out_mem_data), .inst_count(inst_count),
    .cycle_count(cycle_count), .drop_count(drop_count),
    .overflow(overflow), .done(done), .timeout(timeout)
`ifdef CYCLE_STAMP_EN
    , .out_cycle(out_cycle)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: record queue plus plain counters.
  typedef struct {
    logic [3:0]  f;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] rdat;
    logic [15:0] maddr;
    logic [15:0] mdat;
  } mrec_t;

  mrec_t q[$];
  mrec_t r;
  int  mInst, mCyc, mDrop;
  bit  mHalted, mDone, mTo, chkEn;
  bit  mPop, mLd, mSt, mAccept;

  initial chkEn = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      mInst = 0; mCyc = 0; mDrop = 0;
      mHalted = 0; mDone = 0; mTo = 0;
      chkEn = 1'b1;
    end else begin
      mPop = (q.size() > 0) && out_ready;
      mLd = wb_mem_rd && !wb_mem_wr;
      mSt = wb_mem_wr && !wb_mem_rd;
      mAccept = !mHalted && !mTo;
      if (mPop) void'(q.pop_front());
      if (mAccept) begin
        r.f = {wb_halt, mSt, mLd, wb_reg_wr};
        r.pc = wb_pc;
        r.rd = wb_rd;
        r.rdat = wb_reg_data;
        r.maddr = wb_mem_addr;
        r.mdat = mLd ? wb_mem_rdata : (mSt ? wb_mem_wdata : 16'h0);
        if (wb_halt || wb_reg_wr || mSt) mInst++;
        if (r.f != 4'b0) begin
          if (q.size() < DEPTH) q.push_back(r);
          else mDrop++;
        end
        if (wb_halt) mHalted = 1;
      end
      if (!mDone && !mTo) begin
        mCyc++;
        if (mCyc > LIMIT) mTo = 1;
      end
      if (mHalted && !mTo && !mDone && q.size() == 0) mDone = 1;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_flags", out_flags, q[0].f);
        chk("out_pc", out_pc, q[0].pc);
        if (q[0].f[0]) begin
          chk("out_rd", out_rd, q[0].rd);
          chk("out_reg_data", out_reg_data, q[0].rdat);
        end
        if (q[0].f[1] || q[0].f[2])
          chk("out_mem_addr", out_mem_addr, q[0].maddr);
        chk("out_mem_data", out_mem_data, q[0].mdat);
      end
      chk("inst_count", inst_count, mInst);
      chk("cycle_count", cycle_count, mCyc);
      chk("drop_count", drop_count, mDrop);
      chk("overflow", overflow, mDrop > 0);
      chk("done", done, mDone);
      chk("timeout", timeout, mTo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wb_pc = '0; wb_reg_wr = 0; wb_rd = '0; wb_reg_data = '0;
    wb_mem_rd = 0; wb_mem_wr = 0; wb_mem_addr = '0;
    wb_mem_wdata = '0; wb_mem_rdata = '0; wb_halt = 0;
  endtask

  task automatic doReset();
    clr();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic regWrite(input logic [15:0] pc, input logic [3:0] rd,
                          input logic [15:0] d);
    clr();
    wb_pc = pc; wb_reg_wr = 1; wb_rd = rd; wb_reg_data = d;
  endtask

  initial begin
    int n;
    // Reset state
    doReset();
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_inst", inst_count, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_done", done, 0);

    // Register write
    out_ready = 1;
    regWrite(16'h0100, 4'd3, 16'h1234);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_flags", out_flags, 4'b0001);
    chk("t1_rd", out_rd, 3);
    chk("t1_data", out_reg_data, 16'h1234);
    chk("t1_inst", inst_count, 1);

    // Load with register write
    regWrite(16'h0104, 4'd5, 16'hBEEF);
    wb_mem_rd = 1; wb_mem_addr = 16'h0040; wb_mem_rdata = 16'hBEEF;
    step();
    chk("t2_flags", out_flags, 4'b0011);
    chk("t2_mdata", out_mem_data, 16'hBEEF);
    chk("t2_maddr", out_mem_addr, 16'h0040);
    chk("t2_inst", inst_count, 2);

    // Store, then rd&wr together
    clr();
    wb_pc = 16'h0108; wb_mem_wr = 1;
    wb_mem_addr = 16'h0020; wb_mem_wdata = 16'h00AA;
    step();
    chk("t3_flags", out_flags, 4'b0100);
    chk("t3_mdata", out_mem_data, 16'h00AA);
    chk("t3_inst", inst_count, 3);
    clr();
    wb_pc = 16'h010C; wb_mem_rd = 1; wb_mem_wr = 1;
    wb_mem_rdata = 16'h5555; wb_mem_wdata = 16'h6666;
    step();
    chk("t3_norec", out_valid, 0);
    chk("t3_inst2", inst_count, 3);
    clr();
    step();

    // Overflow with consumer stalled
    doReset();
    out_ready = 0;
    for (int i = 0; i < 20; i++) begin
      regWrite(16'h0200 + 16'(i * 4), 4'(i), 16'hA000 + 16'(i));
      step();
    end
    clr();
    chk("t4_drop", drop_count, 4);
    chk("t4_ovf", overflow, 1);
    chk("t4_inst", inst_count, 20);
    chk("t4_head", out_reg_data, 16'hA000);
    out_ready = 1;
    repeat (10) step();
    chk("t4_head10", out_reg_data, 16'hA00A);

    // Reset mid-drain flushes everything
    rst_n = 0;
    step();
    chk("t4_flush_valid", out_valid, 0);
    chk("t4_flush_drop", drop_count, 0);
    chk("t4_flush_ovf", overflow, 0);
    rst_n = 1;

    // Halt behind three queued records
    doReset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      regWrite(16'h0300 + 16'(i * 4), 4'(i + 1), 16'hC000 + 16'(i));
      step();
    end
    clr();
    out_ready = 1;
    wb_halt = 1; wb_pc = 16'h0350;
    step();
    regWrite(16'h0360, 4'd7, 16'h7777);
    n = 0;
    while (!(out_valid && out_flags == 4'b1000) && n < 10) begin
      step();
      n++;
    end
    chk("t5_halt_flags", out_flags, 4'b1000);
    chk("t5_halt_pc", out_pc, 16'h0350);
    chk("t5_inst", inst_count, 4);
    step();
    chk("t5_done", done, 1);
    chk("t5_empty", out_valid, 0);
    repeat (3) step();
    chk("t5_cyc_frozen", cycle_count, 7);
    chk("t5_inst_frozen", inst_count, 4);

    // Timeout without halt
    doReset();
    out_ready = 1;
    repeat (60) step();
    chk("t6_timeout", timeout, 1);
    chk("t6_cycle", cycle_count, 51);
    chk("t6_done", done, 0);
    regWrite(16'h0400, 4'd9, 16'h9999);
    step();
    clr();
    chk("t6_nocap", out_valid, 0);
    chk("t6_noinst", inst_count, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
